ipheader_parse: RTL
===================

// Module: ipheader_parse
// PURPOSE
//  Receive-side counterpart of the IP header builder: after the DM9000A Rx path drops a
//  frame into the packet DPRAM, this block reads the 20-byte IPv4 header at IPHEAD_OFFSET,
//  extracts length/id/protocol/source/destination, and screens the header.
//  It verifies the header checksum through the shared checksum engine and hands the
//  extracted fields to the ICMP/UDP tasks and the Tx header builder.
// PARAMETERS
//  IPHEAD_OFFSET  10'd14   byte address of IP header in DPRAM (after 14-byte Ethernet header)
//  IPHEAD_LENGTH  16'd20   header bytes read/checksummed; IP options are not supported
//  MAX_IP_LEN     16'd1500 largest accepted IP total length
//  RD_LAT         2        cycles from address_b driven to q_b valid
// PORTS
//  iDm9000aClk              in   1   system clock
//  iRunStart                in   1   async active-low reset; rising edge starts one parse run
//  q_b                      in   8   DPRAM port-B read data
//  address_b                out  10  DPRAM port-B address (read only, no write enable)
//  out_to_chksum_RunStart   out  1   checksum request, held high until RunEnd
//  out_to_chksum_len        out  16  bytes to sum (IPHEAD_LENGTH while requesting, else 0)
//  out_to_chksum_start_addr out  10  first byte (IPHEAD_OFFSET while requesting, else 0)
//  in_from_chksum_RunEnd    in   1   checksum result valid
//  in_from_chksum_checksum  in   16  raw one's-complement sum (not inverted)
//  oIpLength/oIpId          out  16  total length / identification
//  oProtoId                 out  8   protocol (1 = ICMP, 17 = UDP)
//  oIpSrc/oIpDest           out  32  source (the PC) / destination IP
//  oIpValid                 out  1   header accepted; meaningful only while oRunEnd = 1
//  oErrCode                 out  3   0 ok, 1 ver/IHL, 2 frag, 3 length, 4 dest IP, 5 checksum
//  oRunEnd                  out  1   parse finished; held until iRunStart low
// BEHAVIOUR
//  - iRunStart low (async): state IDLE, address_b = 0, all field regs/outputs = 0, oRunEnd = 0.
//  - Read loop: ADDR, then WAIT for RD_LAT-1 cycles, then CAP; repeat for cnt = 0..19.
//    address_b = IPHEAD_OFFSET + cnt. One byte captured per pass into a shift/field reg by cnt.
//  - Byte map: 0 ver/IHL, 2-3 length, 4-5 id, 6-7 flags/frag offset, 9 protocol,
//    12-15 source IP, 16-19 destination IP (MSB first). Bytes 1, 8, 10, 11 are captured for
//    the sum only and are not exported.
//  - CHECK (1 cycle), first failure wins, in this order:
//    byte0 != 8'h45 -> 1;
//    MF flag set, or frag offset != 0 (bytes 6-7 & 16'h3FFF) -> 2;
//    length < 20 or > MAX_IP_LEN -> 3;
//    dest != `IP_addr and dest != 32'hFFFF_FFFF -> 4.
//    Any failure: skip CHKSUM, go END with oIpValid = 0.
//  - CHKSUM: address_b = 0 so the checksum engine owns port B.
//    RunStart = 1, len/addr driven.
//    Stay until RunStart & RunEnd, then register the sum; RunStart drops the next cycle.
//  - VERIFY: sum == 16'hFFFF -> oIpValid = 1, oErrCode = 0; otherwise code 5.
//    Sum 16'h0000 is also rejected.
//  - END: oRunEnd = 1, fields stable, self-loop; only iRunStart low leaves it.
//  - States: IDLE, ADDR, WAIT, CAP, CHECK, CHKSUM, VERIFY, END.
//    Best-case latency from the iRunStart rise to oRunEnd is 20*(RD_LAT+1) + 3 cycles
//    plus the checksum engine time.
//  - iRunStart low at any point, including mid-CHKSUM: immediate abort to reset values.
//    RunStart drops asynchronously; the checksum engine must tolerate the abort.
//  - Field outputs are registered and update only on CAP; combinational decode only on
//    chksum len/addr.
// STRUCTURE
//  - Shared DM9000A.def: `IP_addr, plus new `PROTO_ICMP 8'd1, `PROTO_UDP 8'd17 and
//    error-code defines also used by the Rx task dispatcher.
//  - One natural sub-module: ip_dpram_reader (address/latency sequencer producing a byte
//    strobe + index). The FSM and field capture stay in this module.
// TESTING
//  - Valid ICMP echo: 45 00 00 3C 1A 2B 00 00 80 01 <ok csum> C0A8_0064 -> `IP_addr;
//    engine returns FFFF -> oIpValid=1, err 0, len 003C, id 1A2B, proto 01, src C0A80064.
//  - Same frame, one src byte flipped; engine returns sum != FFFF -> oRunEnd=1,
//    oIpValid=0, err 5.
//  - Byte0 = 46 (options) -> err 1, RunStart never asserted.
//  - Flags 20 00 (MF) -> err 2.
//  - Length 0x0013 -> err 3; length 0x05DD -> err 3.
//  - Dest FFFFFFFF -> passes the dest check.
//  - Dest C0A80099 (not ours) -> err 4, no checksum request.
//  - RunEnd delayed 50 cycles -> RunStart held 50 cycles, address_b = 0 throughout.
//  - iRunStart pulled low mid-read (cnt = 9) and again in CHKSUM -> all outputs 0 at once.
//    Restart parses the next frame correctly.

Source files
------------

// File: rtl/ipheader_parse_pkg.sv
// ipheader_parse_pkg: shared constants, state/error encodings and header screening for the Rx IP parser
package ipheader_parse_pkg;
  localparam logic [9:0]  IPHEAD_OFFSET = 10'd14;
  localparam logic [15:0] IPHEAD_LENGTH = 16'd20;
  localparam logic [15:0] MAX_IP_LEN    = 16'd1500;
  localparam int          RD_LAT        = 2;
  localparam logic [31:0] IP_ADDR       = 32'hC0A8_0002;
  localparam logic [7:0]  PROTO_ICMP    = 8'd1;
  localparam logic [7:0]  PROTO_UDP     = 8'd17;
  typedef enum logic [2:0] {ERR_OK, ERR_VER, ERR_FRAG, ERR_LEN, ERR_DEST, ERR_CSUM} err_e;
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, CAP, CHECK, CHKSUM, VERIFY, END} state_e;
  // First failing check wins; DF and the reserved flag bit are ignored.
  function automatic err_e screen(logic [7:0] ver, logic [15:0] frag, logic [15:0] len, logic [31:0] dst);
    return ver != 8'h45 ? ERR_VER :
           |(frag & 16'h3FFF) ? ERR_FRAG :
           (len < IPHEAD_LENGTH || len > MAX_IP_LEN) ? ERR_LEN :
           (dst != IP_ADDR && dst != 32'hFFFF_FFFF) ? ERR_DEST : ERR_OK;
  endfunction
endpackage

// File: rtl/ipheader_parse_if.sv
// ipheader_parse_if: DPRAM port-B read bus plus the checksum engine request/response handshake
interface ipheader_parse_if;
  logic [9:0]  address_b;
  logic [7:0]  q_b;
  logic        out_to_chksum_RunStart;
  logic [15:0] out_to_chksum_len;
  logic [9:0]  out_to_chksum_start_addr;
  logic        in_from_chksum_RunEnd;
  logic [15:0] in_from_chksum_checksum;
  modport master (
    output address_b, out_to_chksum_RunStart, out_to_chksum_len, out_to_chksum_start_addr,
    input  q_b, in_from_chksum_RunEnd, in_from_chksum_checksum
  );
  modport slave (
    input  address_b, out_to_chksum_RunStart, out_to_chksum_len, out_to_chksum_start_addr,
    output q_b, in_from_chksum_RunEnd, in_from_chksum_checksum
  );
endinterface

// File: rtl/ipheader_parse_reader.sv
// ip_dpram_reader: walks the header bytes in DPRAM, timing the read latency and tracking the byte index
module ip_dpram_reader
  import ipheader_parse_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       wait_st,
  input  logic       cap,
  output logic [9:0] addr,
  output logic [4:0] idx,
  output logic       lat_done,
  output logic       last
);
  logic [3:0] lat;
  assign lat_done = lat == 4'(RD_LAT - 2);
  assign last = idx == 5'(IPHEAD_LENGTH - 16'd1);
  // Address is parked at 0 after the last byte so the checksum engine can own port B.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      idx <= '0;
      lat <= '0;
    end else begin
      lat <= wait_st ? lat + 4'd1 : '0;
      if (start) begin
        idx <= '0;
        addr <= IPHEAD_OFFSET;
      end else if (cap) begin
        idx <= idx + 5'd1;
        addr <= last ? '0 : IPHEAD_OFFSET + 10'(idx) + 10'd1;
      end
    end
endmodule

// File: rtl/ipheader_parse.sv
// ipheader_parse: reads the received IPv4 header from DPRAM, screens it and verifies its checksum
module ipheader_parse
  import ipheader_parse_pkg::*;
(
  input  logic             iDm9000aClk,
  input  logic             iRunStart,
  ipheader_parse_if.master bus,
  output logic [15:0]      oIpLength,
  output logic [15:0]      oIpId,
  output logic [7:0]       oProtoId,
  output logic [31:0]      oIpSrc,
  output logic [31:0]      oIpDest,
  output logic             oIpValid,
  output logic [2:0]       oErrCode,
  output logic             oRunEnd
);
  state_e state, state_nx;
  logic [7:0] ver;
  logic [15:0] frag, sum;
  logic [9:0] rd_addr;
  logic [4:0] idx;
  logic lat_done, last;
  err_e err_chk;
  ip_dpram_reader u_rd (
    .clk(iDm9000aClk), .rst_n(iRunStart), .start(state == IDLE), .wait_st(state == WAIT),
    .cap(state == CAP), .addr(rd_addr), .idx(idx), .lat_done(lat_done), .last(last)
  );
  assign bus.address_b = rd_addr;
  assign err_chk = screen(ver, frag, oIpLength, oIpDest);
  always_ff @(posedge iDm9000aClk or negedge iRunStart)
    if (!iRunStart) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = ADDR;
      ADDR:    state_nx = RD_LAT > 1 ? WAIT : CAP;
      WAIT:    state_nx = lat_done ? CAP : WAIT;
      CAP:     state_nx = last ? CHECK : ADDR;
      CHECK:   state_nx = err_chk == ERR_OK ? CHKSUM : END;
      CHKSUM:  state_nx = bus.in_from_chksum_RunEnd ? VERIFY : CHKSUM;
      default: state_nx = END;
    endcase
  end
  always_comb begin
    bus.out_to_chksum_RunStart = state == CHKSUM;
    bus.out_to_chksum_len = state == CHKSUM ? IPHEAD_LENGTH : '0;
    bus.out_to_chksum_start_addr = state == CHKSUM ? IPHEAD_OFFSET : '0;
    oRunEnd = state == END;
  end
  // Multi-byte fields arrive MSB first and are shifted in.
  always_ff @(posedge iDm9000aClk or negedge iRunStart)
    if (!iRunStart) begin
      ver <= '0;
      frag <= '0;
      sum <= '0;
      oIpLength <= '0;
      oIpId <= '0;
      oProtoId <= '0;
      oIpSrc <= '0;
      oIpDest <= '0;
      oIpValid <= 1'b0;
      oErrCode <= '0;
    end else begin
      if (state == CAP) begin
        if (idx == 5'd0) ver <= bus.q_b;
        if (idx inside {[5'd2:5'd3]}) oIpLength <= {oIpLength[7:0], bus.q_b};
        if (idx inside {[5'd4:5'd5]}) oIpId <= {oIpId[7:0], bus.q_b};
        if (idx inside {[5'd6:5'd7]}) frag <= {frag[7:0], bus.q_b};
        if (idx == 5'd9) oProtoId <= bus.q_b;
        if (idx inside {[5'd12:5'd15]}) oIpSrc <= {oIpSrc[23:0], bus.q_b};
        if (idx inside {[5'd16:5'd19]}) oIpDest <= {oIpDest[23:0], bus.q_b};
      end
      if (state == CHECK) oErrCode <= err_chk;
      if (state == CHKSUM && bus.in_from_chksum_RunEnd) sum <= bus.in_from_chksum_checksum;
      if (state == VERIFY) begin
        oIpValid <= sum == 16'hFFFF;
        oErrCode <= sum == 16'hFFFF ? ERR_OK : ERR_CSUM;
      end
    end
endmodule
